// File: rtl/neuron_pkg.sv
// Shared constants and state encoding for the neuron timestep controller.
// Values are Q8.12 signed two's complement.
package neuron_pkg;

  localparam int unsigned W         = 21;
  localparam int unsigned FRAC_BITS = 12;

  // +30.0 in Q8.12
  localparam logic signed [W-1:0] V_TH_DEFAULT = 21'sh01E000;

  typedef enum logic [2:0] {
    StIdle,
    StInteg,
    StCheck,
    StFire,
    StRefr,
    StDone
  } state_e;

endpackage

// File: rtl/neuron_step_ctrl.sv
// Timestep sequencer for one neuron: integrate SUBSTEPS times, threshold, fire, refractory hold.
// The state register and update datapath live in the parent; this block only steers them.
module neuron_step_ctrl
  import neuron_pkg::*;
#(
  parameter int unsigned         SUBSTEPS     = 4,
  parameter int unsigned         REFRAC_STEPS = 3,
  parameter logic signed [W-1:0] V_TH         = V_TH_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         step_valid,
  output logic         step_ready,
  input  logic [W-1:0] i_in,
  input  logic [W-1:0] v_q,
  input  logic [W-1:0] v_next,
  output logic [W-1:0] i_cur,
  output logic [W-1:0] reg_d,
  output logic         reg_set,
  output logic         spike,
  output logic         refrac,
  output logic         step_done
);

  localparam logic [3:0] SubLast = 4'(SUBSTEPS - 1);
  localparam logic [3:0] RefInit = 4'(REFRAC_STEPS);

  state_e       state_q, state_d;
  logic [W-1:0] i_cur_q, i_cur_d;
  logic [3:0]   sub_cnt_q, sub_cnt_d;
  logic [3:0]   ref_cnt_q, ref_cnt_d;
  logic         refrac_q;

  always_comb begin
    state_d    = state_q;
    i_cur_d    = i_cur_q;
    sub_cnt_d  = sub_cnt_q;
    ref_cnt_d  = ref_cnt_q;
    reg_d      = v_q;
    reg_set    = 1'b0;
    spike      = 1'b0;
    step_done  = 1'b0;
    step_ready = 1'b0;

    unique case (state_q)
      StIdle: begin
        step_ready = 1'b1;
        if (step_valid) begin
          // Current is latched even for a refractory step, though it goes unused.
          i_cur_d = i_in;
          if (ref_cnt_q != 4'd0) begin
            state_d = StRefr;
          end else begin
            state_d   = StInteg;
            sub_cnt_d = 4'd0;
          end
        end
      end
      StInteg: begin
        reg_d     = v_next;
        sub_cnt_d = sub_cnt_q + 4'd1;
        if (sub_cnt_q == SubLast) begin
          state_d = StCheck;
        end
      end
      StCheck: begin
        if ($signed(v_q) >= V_TH) begin
          state_d = StFire;
        end else begin
          state_d = StDone;
        end
      end
      StFire: begin
        reg_set   = 1'b1;
        spike     = 1'b1;
        ref_cnt_d = RefInit;
        state_d   = StDone;
      end
      StRefr: begin
        ref_cnt_d = ref_cnt_q - 4'd1;
        state_d   = StDone;
      end
      StDone: begin
        step_done = 1'b1;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      i_cur_q   <= '0;
      sub_cnt_q <= 4'd0;
      ref_cnt_q <= 4'd0;
      refrac_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      i_cur_q   <= i_cur_d;
      sub_cnt_q <= sub_cnt_d;
      ref_cnt_q <= ref_cnt_d;
      refrac_q  <= (ref_cnt_d != 4'd0);
    end
  end

  assign i_cur  = i_cur_q;
  assign refrac = refrac_q;

endmodule

// File: tb/tb_neuron_step_ctrl.sv
// Scoreboard bench: driver models each accepted step arithmetically, monitor checks each step_done.
module tb_neuron_step_ctrl;

  localparam int unsigned SUBSTEPS     = 4;
  localparam int unsigned REFRAC_STEPS = 3;
  localparam int          VTH_INT      = 'h1E000;
  localparam int          VRESET_INT   = -'h0D000;

  typedef struct {
    int          lat;
    bit          spk;
    logic [20:0] v;
    bit          refr;
    logic [20:0] icur;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        step_valid;
  logic        step_ready;
  logic [20:0] i_in;
  logic [20:0] v_next;
  logic [20:0] i_cur;
  logic [20:0] reg_d;
  logic        reg_set;
  logic        spike;
  logic        refrac;
  logic        step_done;

  // Environment: state register with set priority, and an adder datapath.
  logic [20:0] v_reg = '0;
  logic        load;
  logic [20:0] load_val;

  always @(posedge clk) begin
    if (load)         v_reg <= load_val;
    else if (reg_set) v_reg <= 21'(VRESET_INT);
    else              v_reg <= reg_d;
  end
  assign v_next = v_reg + i_cur;

  neuron_step_ctrl #(
    .SUBSTEPS    (SUBSTEPS),
    .REFRAC_STEPS(REFRAC_STEPS),
    .V_TH        (21'sh01E000)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .step_valid(step_valid),
    .step_ready(step_ready),
    .i_in      (i_in),
    .v_q       (v_reg),
    .v_next    (v_next),
    .i_cur     (i_cur),
    .reg_d     (reg_d),
    .reg_set   (reg_set),
    .spike     (spike),
    .refrac    (refrac),
    .step_done (step_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_total = 0;
  int   n_bad   = 0;
  exp_t exp_q[$];
  int   acc_q[$];
  int   v_m;
  int   ref_m;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic int wrap21(input int x);
    logic signed [20:0] t;
    t = x[20:0];
    return int'(t);
  endfunction

  // Reference: a step either burns one refractory count or adds SUBSTEPS*i then thresholds.
  task automatic model_accept(input logic [20:0] i);
    exp_t e;
    e.icur = i;
    if (ref_m > 0) begin
      ref_m--;
      e.lat = 2;
      e.spk = 1'b0;
    end else begin
      v_m = wrap21(v_m + int'(SUBSTEPS) * int'($signed(i)));
      if (v_m >= VTH_INT) begin
        e.spk = 1'b1;
        v_m   = VRESET_INT;
        ref_m = int'(REFRAC_STEPS);
        e.lat = int'(SUBSTEPS) + 3;
      end else begin
        e.spk = 1'b0;
        e.lat = int'(SUBSTEPS) + 2;
      end
    end
    e.v    = 21'(v_m);
    e.refr = (ref_m != 0);
    exp_q.push_back(e);
  endtask

  // Called at a negedge; returns at the next negedge.
  task automatic issue(input bit v, input int i);
    step_valid = v;
    i_in       = 21'(i);
    #1;
    if (v && step_ready) model_accept(i_in);
    @(negedge clk);
  endtask

  task automatic preload(input int v);
    load     = 1'b1;
    load_val = 21'(v);
    v_m      = wrap21(v);
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic drain();
    step_valid = 1'b0;
    for (int k = 0; k < 60; k++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    chk("drain_pending", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    acc_q.delete();
  endtask

  // Monitor
  int          cyc = 0;
  bit          spike_seen;
  bit          prev_acc;
  logic [20:0] prev_icur;
  exp_t        me;
  int          ma;

  always begin
    @(negedge clk);
    #2;
    if (!rst_n) begin
      spike_seen = 1'b0;
      prev_acc   = 1'b0;
      prev_icur  = i_cur;
    end else begin
      cyc++;
      if (step_valid && step_ready) acc_q.push_back(cyc);
      if (i_cur != prev_icur) chk("icur_only_on_accept", 32'(prev_acc), 32'd1);
      if (spike) begin
        spike_seen = 1'b1;
        chk("set_with_spike", 32'(reg_set), 32'd1);
      end
      if (step_done) begin
        chk("ready_low_in_done", 32'(step_ready), 32'd0);
        if (exp_q.size() == 0 || acc_q.size() == 0) begin
          n_total++;
          n_bad++;
          $display("FAIL unexpected_done: got step_done=1 want no pending step at %0t", $time);
        end else begin
          me = exp_q.pop_front();
          ma = acc_q.pop_front();
          chk("latency", 32'(cyc - ma), 32'(me.lat));
          chk("spike", 32'(spike_seen), 32'(me.spk));
          chk("v_after_step", 32'(v_reg), 32'(me.v));
          chk("refrac_at_done", 32'(refrac), 32'(me.refr));
          chk("i_cur_latched", 32'(i_cur), 32'(me.icur));
        end
        spike_seen = 1'b0;
      end
      prev_acc  = step_valid && step_ready;
      prev_icur = i_cur;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b1;
    step_valid = 1'b0;
    i_in       = '0;
    load       = 1'b0;
    load_val   = '0;
    v_m        = 0;
    ref_m      = 0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_ready", 32'(step_ready), 32'd1);
    chk("rst_set", 32'(reg_set), 32'd0);
    chk("rst_spike", 32'(spike), 32'd0);
    chk("rst_done", 32'(step_done), 32'd0);
    chk("rst_refrac", 32'(refrac), 32'd0);
    chk("rst_icur", 32'(i_cur), 32'd0);
    chk("rst_reg_d_hold", 32'(reg_d), 32'(v_reg));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset while integrating (sub_cnt==2)
    preload(0);
    issue(1'b1, 'h1000);
    step_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    acc_q.delete();
    ref_m = 0;
    chk("midrst_ready", 32'(step_ready), 32'd1);
    chk("midrst_spike", 32'(spike), 32'd0);
    chk("midrst_done", 32'(step_done), 32'd0);
    chk("midrst_set", 32'(reg_set), 32'd0);
    chk("midrst_icur", 32'(i_cur), 32'd0);
    chk("midrst_reg_d_hold", 32'(reg_d), 32'(v_reg));
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      #1;
      chk("midrst_quiet", 32'({spike, step_done}), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("midrst_ready_after", 32'(step_ready), 32'd1);
    @(negedge clk);

    // Sub-threshold step
    preload(0);
    issue(1'b1, 'h1000);
    drain();

    // Threshold-equal fire, three refractory steps, then a normal step
    preload('h1A000);
    issue(1'b1, 'h1000);
    drain();
    for (int k = 0; k < 4; k++) begin
      issue(1'b1, 'h1000 + k);
      drain();
    end

    // Negative potential and large negative drive, then positive drive crossing later
    preload(-'h0D000);
    issue(1'b1, -'h8000);
    drain();
    issue(1'b1, 'h10000);
    drain();
    issue(1'b1, 'h10000);
    drain();

    // Random valid with random current
    for (int k = 0; k < 250; k++) begin
      issue(($urandom % 3) != 0, int'($urandom_range(0, 'h5000)) - 'h2000);
    end
    drain();

    // Valid held high continuously, current changing every cycle
    for (int k = 0; k < 200; k++) begin
      issue(1'b1, int'($urandom_range(0, 'h5000)) - 'h2000);
    end
    drain();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/neuron_step_ctrl.md
Name: neuron_step_ctrl

Overview:
- Sequencer for one neuron's 21-bit signed membrane-potential register and its Euler-update datapath.
- Runs one timestep per accepted request:
  - captures the input current;
  - issues SUBSTEPS integration updates;
  - checks threshold;
  - on crossing, pulses the register's set input (loads its fixed reset potential) and emits a spike;
  - then enforces a refractory window.
- Sits between the global timestep scheduler (valid/ready) and the state register / update datapath.

Parameters:
- W, 21, datapath word width (signed two's complement, Q8.12).
- SUBSTEPS, 4, integration updates per timestep, range 1..15.
- REFRAC_STEPS, 3, timesteps the neuron is held after a spike, range 0..15.
- V_TH, 21'sh01E000, signed firing threshold (+30.0 in Q8.12).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- step_valid  in  1  scheduler requests one timestep.
- step_ready  out  1  controller can accept a timestep.
- i_in  in  W  signed input current; sampled on the accept cycle.
- v_q  in  W  current register output (feedback).
- v_next  in  W  datapath result f(v_q, i_cur), combinational.
- i_cur  out  W  latched current driven to the datapath.
- reg_d  out  W  d input of the state register.
- reg_set  out  1  set input of the state register.
- spike  out  1  one-cycle spike pulse.
- refrac  out  1  high while the neuron is refractory.
- step_done  out  1  one-cycle pulse when a timestep completes.

Behaviour:
- The register loads d every clock, so the controller drives reg_d = v_q (hold) in every state except INTEG, where reg_d = v_next.
- The register's set has priority over d.

Reset (async, rst_n=0):
- state=IDLE; step_ready=1; reg_set=0; spike=0; step_done=0; refrac=0.
- i_cur=0; sub_cnt=0; ref_cnt=0; reg_d=v_q.
- Reset mid-operation aborts the step with no spike and no done pulse.
- The register keeps its last value. It is not forced by this block.

States:
- IDLE:
  - step_ready=1.
  - On step_valid&step_ready: latch i_cur<=i_in.
  - If ref_cnt!=0: go to REFR. Otherwise: go to INTEG with sub_cnt<=0.
- INTEG:
  - reg_d=v_next; sub_cnt increments each cycle.
  - After SUBSTEPS cycles (sub_cnt==SUBSTEPS-1): go to CHECK.
  - Exactly SUBSTEPS register updates occur.
- CHECK (1 cycle):
  - Compare v_q (already updated) against V_TH, signed, using >=.
  - If true: go to FIRE. Otherwise: go to DONE.
- FIRE (1 cycle):
  - reg_set=1; spike=1; ref_cnt<=REFRAC_STEPS.
  - Go to DONE.
- REFR (1 cycle):
  - Register held; refrac=1; ref_cnt decrements.
  - Input is ignored, except i_cur is still latched.
  - Go to DONE.
- DONE (1 cycle):
  - step_done=1.
  - Go to IDLE.

Latency and handshake:
- Accept cycle to step_done:
  - non-refractory step: SUBSTEPS+2 cycles (spike path SUBSTEPS+3);
  - refractory step: 2 cycles.
- step_ready is low from the cycle after accept until IDLE is re-entered.
- step_valid held high while not ready is ignored. No queueing.

Refractory flag:
- refrac=(ref_cnt!=0), registered.
- With REFRAC_STEPS=0, a spike sets no refractory period.

Arithmetic:
- Comparison is full-width signed. No saturation here; overflow is the datapath's responsibility.
- Threshold exactly equal to v_q fires.

Simultaneous events:
- step_valid in the DONE cycle is not accepted; ready rises in IDLE.

Decomposition:
- Shared package (neuron_pkg):
  - W;
  - Q-format fraction bits (12);
  - default V_TH;
  - state enum {IDLE, INTEG, CHECK, FIRE, REFR, DONE}.
- No sub-module. The existing state register and update datapath are instantiated alongside this block by the parent, not inside it.

Test Plan:
- Reset mid-INTEG (rst_n low at sub_cnt=2) -> outputs go to reset values immediately. No spike or step_done. step_ready=1 after release.
- Sub-threshold step: v_q=0, datapath v_next=v_q+0x1000, SUBSTEPS=4 -> exactly 4 updates to 0x4000, spike=0, step_done 6 cycles after accept.
- Threshold-equal fire: start v=0x1A000, increment 0x1000 -> v reaches 0x1E000, spike=1 and reg_set=1 same cycle, refrac=1 next cycle, step_done at cycle 7.
- Refractory: after a fire with REFRAC_STEPS=3 -> the next 3 steps each complete in 2 cycles with reg_d=v_q, no updates and refrac=1. The 4th step integrates normally and refrac is 0.
- Handshake: step_valid held high continuously -> one accept per step_ready window. i_cur changes only on accept cycles. No accept in the DONE cycle.
- Negative values: v_q=-0x0D000, V_TH=0x1E000, large negative v_next -> no fire (signed compare). A positive i_in crossing later fires once.
